// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake FIFO slice.
package handshake_pkg;

  localparam int unsigned default_data_width = 32;
  localparam int unsigned stats_width        = 32;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4,
  localparam int unsigned aw        = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [aw-1:0]         waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [aw-1:0]         raddr,
  output logic [data_width-1:0] rdata_c
);

  logic [data_width-1:0] mem [depth];

  // Contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer decoupling two req/ack handshakes.
// Optional statistics outputs are built when HANDSHAKE_FIFO_STATS_EN is defined.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned data_width = default_data_width,
  parameter int unsigned depth      = 4,
  localparam int unsigned aw        = $clog2(depth),
  localparam int unsigned ow        = occ_width(depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   in_req,
  input  logic                   in_ack,
  input  logic [data_width-1:0]  in_data,
  input  logic                   out_req,
  output logic                   out_ack,
  output logic [data_width-1:0]  out_data,
  output logic [ow-1:0]          occupancy,
  output logic                   overflow
`ifdef HANDSHAKE_FIFO_STATS_EN
  ,
  output logic [stats_width-1:0] count_in,
  output logic [stats_width-1:0] count_out,
  output logic [ow-1:0]          max_occ
`endif
);

  localparam logic [ow-1:0] full_lvl = ow'(depth);
  localparam logic [ow-1:0] high_lvl = ow'(depth - 1);

  logic [aw-1:0]         wp;
  logic [aw-1:0]         rp;
  logic [ow-1:0]         occ_next;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [data_width-1:0] rd_word;

  fifo_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk     (clk),
    .we      (wr_fire),
    .waddr   (wp),
    .wdata   (in_data),
    .raddr   (rp),
    .rdata_c (rd_word)
  );

  // A read needs a word stored before this edge, so a write never bypasses.
  // A full buffer still accepts a word when a read frees a slot on the same edge.
  always_comb begin
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    occ_next = occupancy;
    rd_fire  = out_req && !out_ack && (occupancy != '0);
    wr_fire  = in_ack && ((occupancy != full_lvl) || rd_fire);
    if (wr_fire && !rd_fire) begin
      occ_next = occupancy + ow'(1);
    end else if (!wr_fire && rd_fire) begin
      occ_next = occupancy - ow'(1);
    end
  end

  // Pointers, occupancy and both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      occupancy <= '0;
      in_req    <= 1'b0;
      out_ack   <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      occupancy <= occ_next;
      // Keep one slot free for an ack already in flight.
      in_req    <= (occ_next < high_lvl);
      out_ack   <= rd_fire;
      if (wr_fire) wp <= wp + aw'(1);
      if (rd_fire) begin
        rp       <= rp + aw'(1);
        out_data <= rd_word;
      end
      if (in_ack && !wr_fire) overflow <= 1'b1;
    end
  end

`ifdef HANDSHAKE_FIFO_STATS_EN
  // Traffic counters wrap naturally; max_occ tracks the peak stored count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_in  <= '0;
      count_out <= '0;
      max_occ   <= '0;
    end else begin
      if (wr_fire) count_in <= count_in + stats_width'(1);
      if (rd_fire) count_out <= count_out + stats_width'(1);
      if (occ_next > max_occ) max_occ <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_fifo.sv
// Self-checking bench for handshake_fifo: queue-based reference model plus directed and random traffic.
module tb_handshake_fifo;

  localparam int data_width = 32;
  localparam int depth      = 4;
  localparam int ow         = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_req;
  logic                  in_ack;
  logic [data_width-1:0] in_data;
  logic                  out_req;
  logic                  out_ack;
  logic [data_width-1:0] out_data;
  logic [ow-1:0]         occupancy;
  logic                  overflow;
`ifdef HANDSHAKE_FIFO_STATS_EN
  logic [31:0]           count_in;
  logic [31:0]           count_out;
  logic [ow-1:0]         max_occ;
`endif

  handshake_fifo #(
    .data_width (data_width),
    .depth      (depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .occupancy (occupancy),
    .overflow  (overflow)
`ifdef HANDSHAKE_FIFO_STATS_EN
    ,
    .count_in  (count_in),
    .count_out (count_out),
    .max_occ   (max_occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic                  s_valid = 1'b0;
  logic                  s_rst;
  logic                  s_in_ack;
  logic                  s_out_req;
  logic [data_width-1:0] s_in_data;

  always @(posedge clk) begin
    s_valid   <= 1'b1;
    s_rst     <= rst;
    s_in_ack  <= in_ack;
    s_out_req <= out_req;
    s_in_data <= in_data;
  end

  // Reference model: a word queue plus the handshake rules, advanced once per edge.
  logic [data_width-1:0] q[$];
  logic                  m_in_req   = 1'b0;
  logic                  m_out_ack  = 1'b0;
  logic                  m_ovf      = 1'b0;
  logic [data_width-1:0] m_out_data = '0;
  int                    m_cin      = 0;
  int                    m_cout     = 0;
  int                    m_peak     = 0;

  always @(negedge clk) begin : model_and_compare
    bit rd;
    bit wr;
    if (s_valid) begin
      if (s_rst) begin
        q.delete();
        m_in_req   = 1'b0;
        m_out_ack  = 1'b0;
        m_out_data = '0;
        m_ovf      = 1'b0;
        m_cin      = 0;
        m_cout     = 0;
        m_peak     = 0;
      end else begin
        rd = s_out_req && !m_out_ack && (q.size() > 0);
        wr = s_in_ack && ((q.size() < depth) || rd);
        if (rd) begin
          m_out_data = q.pop_front();
          m_cout++;
        end
        m_out_ack = rd;
        if (wr) begin
          q.push_back(s_in_data);
          m_cin++;
        end else if (s_in_ack) begin
          m_ovf = 1'b1;
        end
        if (q.size() > m_peak) m_peak = q.size();
        m_in_req = (q.size() < depth - 1);
      end
      check("cmp_in_req", 64'(in_req), 64'(m_in_req));
      check("cmp_out_ack", 64'(out_ack), 64'(m_out_ack));
      check("cmp_out_data", 64'(out_data), 64'(m_out_data));
      check("cmp_occupancy", 64'(occupancy), 64'(q.size()));
      check("cmp_overflow", 64'(overflow), 64'(m_ovf));
`ifdef HANDSHAKE_FIFO_STATS_EN
      check("cmp_count_in", 64'(count_in), 64'(m_cin));
      check("cmp_count_out", 64'(count_out), 64'(m_cout));
      check("cmp_max_occ", 64'(max_occ), 64'(m_peak));
`endif
    end
  end

  // Advance to the next cycle in which out_ack is high, bounded.
  task automatic wait_out_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_ack && n < 20);
    check(name, 64'(out_ack), 64'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int rcvd;
    int cyc;

    rst     = 1'b1;
    in_ack  = 1'b0;
    in_data = '0;
    out_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_req_low", 64'(in_req), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_req", 64'(in_req), 64'd1);
    check("idle_out_ack", 64'(out_ack), 64'd0);
    check("idle_occ", 64'(occupancy), 64'd0);
    check("idle_out_data", 64'(out_data), 64'd0);

    // Single word with minimum latency.
    in_ack  = 1'b1;
    in_data = 7;
    out_req = 1'b1;
    @(negedge clk);
    in_ack = 1'b0;
    check("w7_occ1", 64'(occupancy), 64'd1);
    check("w7_no_bypass", 64'(out_ack), 64'd0);
    @(negedge clk);
    check("w7_ack", 64'(out_ack), 64'd1);
    check("w7_data", 64'(out_data), 64'd7);
    check("w7_occ0", 64'(occupancy), 64'd0);
    @(negedge clk);
    check("w7_single_pulse", 64'(out_ack), 64'd0);
    out_req = 1'b0;

    // Fill to depth with the in-flight word, then force an overflow.
    for (int k = 1; k <= 3; k++) begin
      in_ack  = 1'b1;
      in_data = data_width'(k);
      @(negedge clk);
    end
    check("fill_occ3", 64'(occupancy), 64'd3);
    check("fill_in_req_low", 64'(in_req), 64'd0);
    in_data = 4;
    @(negedge clk);
    check("fill_occ4", 64'(occupancy), 64'd4);
    check("fill_no_ovf", 64'(overflow), 64'd0);
    in_data = 5;
    @(negedge clk);
    in_ack = 1'b0;
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_occ4", 64'(occupancy), 64'd4);
    out_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_out_ack("drain_ack");
      check("drain_data", 64'(out_data), 64'(k));
    end
    @(negedge clk);
    check("drain_occ0", 64'(occupancy), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    out_req = 1'b0;

    // Reset with three words stored; an ack during reset must be ignored.
    for (int k = 11; k <= 13; k++) begin
      in_ack  = 1'b1;
      in_data = data_width'(k);
      @(negedge clk);
    end
    check("pre_rst_occ3", 64'(occupancy), 64'd3);
    rst     = 1'b1;
    in_data = 99;
    @(negedge clk);
    rst    = 1'b0;
    in_ack = 1'b0;
    check("mid_rst_occ0", 64'(occupancy), 64'd0);
    check("mid_rst_out_ack", 64'(out_ack), 64'd0);
    check("mid_rst_ovf_clr", 64'(overflow), 64'd0);
    @(negedge clk);
    check("post_rst_in_req", 64'(in_req), 64'd1);
    in_ack  = 1'b1;
    in_data = 42;
    out_req = 1'b1;
    @(negedge clk);
    in_ack = 1'b0;
    wait_out_ack("w42_ack");
    check("w42_first", 64'(out_data), 64'd42);
    out_req = 1'b0;

    // Randomized stream honouring in_req, with random consumer stalls.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 10000 && cyc < 50000) begin
      if (in_req && sent < 10000 && $urandom_range(3) != 0) begin
        in_ack  = 1'b1;
        in_data = data_width'(sent);
        sent++;
      end else begin
        in_ack = 1'b0;
      end
      out_req = ($urandom_range(3) != 0);
      @(negedge clk);
      cyc++;
      if (out_ack) begin
        check("stream_order", 64'(out_data), 64'(rcvd));
        rcvd++;
      end
    end
    in_ack  = 1'b0;
    out_req = 1'b0;
    check("stream_received", 64'(rcvd), 64'd10000);
    check("stream_no_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    check("stream_empty", 64'(occupancy), 64'd0);
`ifdef HANDSHAKE_FIFO_STATS_EN
    check("stats_count_in", 64'(count_in), 64'd10000);
    check("stats_count_out", 64'(count_out), 64'd10000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
